// File: rtl/baud_tick_gen_pkg.sv
// baud_tick_gen_pkg: board defaults and limits for the UART baud-rate generator
package baud_tick_gen_pkg;
  localparam int DIV_W_DEFAULT  = 16;
  localparam int FRAC_W_DEFAULT = 4;
  localparam int OSR_DEFAULT    = 16;
  localparam int BOARD_DEF_DIV  = 312;
  localparam int BOARD_DEF_FRAC = 8;
  localparam int MIN_DIV        = 2;
endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: divisor programming and tick outputs of the baud-rate generator
interface baud_tick_gen_if import baud_tick_gen_pkg::*; #(
  parameter int DIV_W  = DIV_W_DEFAULT,
  parameter int FRAC_W = FRAC_W_DEFAULT
);
  logic              en_i;
  logic              load_i;
  logic [DIV_W-1:0]  div_int_i;
  logic [FRAC_W-1:0] div_frac_i;
  logic              os_tick_o;
  logic              mid_tick_o;
  logic              bit_tick_o;
  logic              cfg_err_o;
  modport master (output en_i, load_i, div_int_i, div_frac_i,
                  input  os_tick_o, mid_tick_o, bit_tick_o, cfg_err_o);
  modport slave  (input  en_i, load_i, div_int_i, div_frac_i,
                  output os_tick_o, mid_tick_o, bit_tick_o, cfg_err_o);
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional baud-rate generator producing oversample, mid-bit and bit ticks
module baud_tick_gen import baud_tick_gen_pkg::*; #(
  parameter int DIV_W    = DIV_W_DEFAULT,
  parameter int FRAC_W   = FRAC_W_DEFAULT,
  parameter int OSR      = OSR_DEFAULT,
  parameter int DEF_DIV  = BOARD_DEF_DIV,
  parameter int DEF_FRAC = BOARD_DEF_FRAC
) (
  input logic           clk,
  input logic           rst_n,
  baud_tick_gen_if.slave bus
);
  localparam int OS_W = $clog2(OSR);
  logic [DIV_W-1:0]  div_int_q, cyc_cnt_q, lim;
  logic [FRAC_W-1:0] div_frac_q, frac_acc_q;
  logic [FRAC_W:0]   frac_sum;
  logic [OS_W-1:0]   os_cnt_q;
  logic              extra_q, cfg_err_q, os_tick_q, mid_tick_q, bit_tick_q;
  logic              run, wrap;
  // load takes priority over counting, so a coincident wrap never produces a tick
  always_comb begin
    lim      = div_int_q - DIV_W'(1) + DIV_W'(extra_q);
    run      = bus.en_i && !cfg_err_q && !bus.load_i;
    wrap     = run && (cyc_cnt_q == lim);
    frac_sum = {1'b0, frac_acc_q} + {1'b0, div_frac_q};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_int_q  <= DIV_W'(DEF_DIV);
      div_frac_q <= FRAC_W'(DEF_FRAC);
      cfg_err_q  <= 1'b0;
      cyc_cnt_q  <= '0;
      os_tick_q  <= 1'b0;
    end else begin
      if (bus.load_i) begin
        div_int_q  <= bus.div_int_i;
        div_frac_q <= bus.div_frac_i;
        cfg_err_q  <= bus.div_int_i < DIV_W'(MIN_DIV);
      end
      cyc_cnt_q <= (bus.load_i || wrap) ? '0 : run ? cyc_cnt_q + DIV_W'(1) : cyc_cnt_q;
      os_tick_q <= wrap;
    end
  end
  // the carry out of the fractional add lengthens the following period by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_acc_q <= '0;
      extra_q    <= 1'b0;
    end else if (bus.load_i) begin
      frac_acc_q <= '0;
      extra_q    <= 1'b0;
    end else if (wrap) begin
      {extra_q, frac_acc_q} <= frac_sum;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_q   <= '0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      os_cnt_q   <= bus.load_i ? '0 : wrap ? os_cnt_q + OS_W'(1) : os_cnt_q;
      mid_tick_q <= wrap && (os_cnt_q == OS_W'(OSR / 2 - 1));
      bit_tick_q <= wrap && (os_cnt_q == OS_W'(OSR - 1));
    end
  end
  assign bus.os_tick_o  = os_tick_q;
  assign bus.mid_tick_o = mid_tick_q;
  assign bus.bit_tick_o = bit_tick_q;
  assign bus.cfg_err_o  = cfg_err_q;
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: scoreboard of expected tick cycles built from the divisor arithmetic
module tb_baud_tick_gen;
  typedef struct {int cyc; bit mid; bit bt;} exp_t;
  typedef struct {int d; int f; int n; bit err; int span;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc_n = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   tick_log[$];
  int   bit_log[$];
  baud_tick_gen_if bus();
  baud_tick_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    bit eo, em, eb;
    eo = 1'b0;
    em = 1'b0;
    eb = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc_n) begin
      eo = 1'b1;
      em = q[0].mid;
      eb = q[0].bt;
      void'(q.pop_front());
    end
    if (bus.os_tick_o) tick_log.push_back(cyc_n);
    if (bus.bit_tick_o) bit_log.push_back(cyc_n);
    if (eo || bus.os_tick_o || bus.mid_tick_o || bus.bit_tick_o)
      chk($sformatf("ticks_os_mid_bit@%0d", cyc_n),
          int'({bus.os_tick_o, bus.mid_tick_o, bus.bit_tick_o}), int'({eo, em, eb}));
  end
  // period k is d plus the carry produced by the (k-1)-th fractional add
  task automatic push_ticks(input int base, input int d, input int f, input int n);
    int t;
    t = base;
    for (int k = 1; k <= n; k++) begin
      t += d + ((k > 1) ? ((k - 1) * f / 16 - (k - 2) * f / 16) : 0);
      q.push_back('{t, (k % 16) == 8, (k % 16) == 0});
    end
  endtask
  task automatic flush_from(input int c);
    exp_t keep[$];
    foreach (q[i]) if (q[i].cyc < c) keep.push_back(q[i]);
    q = keep;
  endtask
  task automatic shift_from(input int c, input int g);
    foreach (q[i]) if (q[i].cyc >= c) q[i].cyc += g;
  endtask
  task automatic wait_empty(input int budget, input string name);
    int c;
    c = 0;
    while (q.size() > 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_timeout_pending"}, q.size(), 0);
    q.delete();
  endtask
  task automatic do_load(input int d, input int f, input int n, input bit err, output int l);
    @(posedge clk);
    #2;
    bus.load_i     = 1'b1;
    bus.div_int_i  = 16'(d);
    bus.div_frac_i = 4'(f);
    l = cyc_n + 1;
    flush_from(l);
    push_ticks(l, d, f, n);
    @(posedge clk);
    #2;
    bus.load_i = 1'b0;
    tick_log.delete();
    bit_log.delete();
    chk($sformatf("cfg_err_div%0d", d), int'(bus.cfg_err_o), int'(err));
  endtask
  initial begin
    vec_t v[6];
    int   l, l2, base, c;
    v[0] = '{4, 0, 17, 1'b0, 64};
    v[1] = '{5, 3, 17, 1'b0, 83};
    v[2] = '{1, 0, 0, 1'b1, 0};
    v[3] = '{0, 5, 0, 1'b1, 0};
    v[4] = '{3, 0, 4, 1'b0, 9};
    v[5] = '{7, 15, 20, 1'b0, 150};
    bus.en_i       = 1'b1;
    bus.load_i     = 1'b0;
    bus.div_int_i  = '0;
    bus.div_frac_i = '0;
    #1;
    chk("rst_os_tick", int'(bus.os_tick_o), 0);
    chk("rst_mid_tick", int'(bus.mid_tick_o), 0);
    chk("rst_bit_tick", int'(bus.bit_tick_o), 0);
    chk("rst_cfg_err", int'(bus.cfg_err_o), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = cyc_n;
    push_ticks(base, 312, 8, 32);
    wait_empty(11000, "default");
    chk("default_first", tick_log[0] - base, 312);
    chk("default_p2", tick_log[1] - tick_log[0], 312);
    chk("default_p3", tick_log[2] - tick_log[1], 313);
    chk("default_bit_period", bit_log[1] - bit_log[0], 5000);
    chk("default_cfg_err", int'(bus.cfg_err_o), 0);
    foreach (v[i]) begin
      do_load(v[i].d, v[i].f, v[i].n, v[i].err, l);
      if (v[i].n > 0) begin
        wait_empty(v[i].n * 20 + 50, $sformatf("vec%0d", i));
        chk($sformatf("vec%0d_first", i), tick_log[0] - l, v[i].d);
        chk($sformatf("vec%0d_span", i), tick_log[v[i].n - 1] - tick_log[0], v[i].span);
        chk($sformatf("vec%0d_count", i), tick_log.size(), v[i].n);
      end else begin
        repeat (100) @(negedge clk);
        chk($sformatf("vec%0d_quiet", i), tick_log.size(), 0);
      end
    end
    do_load(10, 0, 4, 1'b0, l);
    while (cyc_n < l + 14) begin
      @(posedge clk);
      #2;
    end
    bus.en_i = 1'b0;
    shift_from(l + 15, 7);
    repeat (7) @(posedge clk);
    #2;
    bus.en_i = 1'b1;
    wait_empty(200, "gap");
    chk("gap_period", tick_log[1] - tick_log[0], 17);
    chk("gap_after", tick_log[2] - tick_log[1], 10);
    do_load(4, 0, 10, 1'b0, l);
    while (cyc_n < l + 6) begin
      @(posedge clk);
      #2;
    end
    do_load(6, 0, 10, 1'b0, l2);
    c = 0;
    while (tick_log.size() < 2 && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("coinc_first", tick_log[0] - l2, 6);
    c = 0;
    while (!bus.os_tick_o && c < 50) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("pre_rst_tick_seen", int'(bus.os_tick_o), 1);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_os_tick", int'(bus.os_tick_o), 0);
    chk("async_rst_cfg_err", int'(bus.cfg_err_o), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    base = cyc_n;
    tick_log.delete();
    push_ticks(base, 312, 8, 2);
    wait_empty(800, "post_rst");
    chk("post_rst_first", tick_log[0] - base, 312);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
